// File: rtl/riscv_trap_ctl.sv
// Machine-mode trap controller: M-mode trap CSRs, exception/interrupt arbitration, MRET, PC redirect.
// Optional feature macro: RISCV_TRAP_VECTORED_EN enables vectored mtvec mode (MODE=1).
module riscv_trap_ctl #(
  parameter int             XLEN      = 64,
  parameter logic [XLEN-1:0] RST_MTVEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_vld,
  input  logic [5:0]      exc_cause,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            ret_vld,
  input  logic            irq_ext,
  input  logic            irq_tmr,
  input  logic            irq_sft,
  input  logic            csr_wen,
  input  logic [11:0]     csr_adr,
  input  logic [XLEN-1:0] csr_wdt,
  output logic [XLEN-1:0] csr_rdt,
  output logic            csr_ill,
  output logic            stall,
  output logic            ctl_req,
  output logic [XLEN-1:0] ctl_pc
);

  localparam logic [11:0] ADR_MSTATUS = 12'h300;
  localparam logic [11:0] ADR_MIE     = 12'h304;
  localparam logic [11:0] ADR_MTVEC   = 12'h305;
  localparam logic [11:0] ADR_MEPC    = 12'h341;
  localparam logic [11:0] ADR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADR_MTVAL   = 12'h343;
  localparam logic [11:0] ADR_MIP     = 12'h344;

  typedef enum logic [1:0] {IDLE, ENTER, RETURN} state_t;
  state_t state_reg, state_next;

  logic            st_mie_reg, st_mpie_reg;
  logic [2:0]      irq_en_reg;   // index 0=MSI(3), 1=MTI(7), 2=MEI(11)
  logic [2:0]      mip_reg;
  logic [XLEN-3:0] mtvec_base_reg;
  logic [1:0]      mtvec_mode;
  logic [XLEN-2:0] mepc_reg;
  logic            mcause_intr_reg;
  logic [5:0]      mcause_code_reg;
  logic [XLEN-1:0] mtval_reg;
  logic [XLEN-1:0] ctl_pc_reg;

  logic [2:0]      irq_pend;
  logic            irq_take, take_exc, take_irq, take_ret, hw_evt;
  logic [5:0]      irq_code;
  logic [XLEN-1:0] base_pc, trap_pc;
  logic [XLEN-1:0] mie_rd, mip_rd;

  // Arbitration: exception > enabled interrupt > MRET, only when idle.
  assign irq_pend = mip_reg & irq_en_reg;
  assign irq_take = st_mie_reg & (|irq_pend);
  assign irq_code = irq_pend[2] ? 6'd11 : (irq_pend[0] ? 6'd3 : 6'd7);
  assign take_exc = (state_reg == IDLE) & exc_vld;
  assign take_irq = (state_reg == IDLE) & ~exc_vld & irq_take;
  assign take_ret = (state_reg == IDLE) & ~exc_vld & ~irq_take & ret_vld;
  assign hw_evt   = take_exc | take_irq | take_ret;

  assign base_pc = {mtvec_base_reg, 2'b00};
  assign trap_pc = (take_irq && mtvec_mode == 2'd1) ?
                   base_pc + {{(XLEN-8){1'b0}}, irq_code, 2'b00} : base_pc;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (take_exc || take_irq) state_next = ENTER;
        else if (take_ret)        state_next = RETURN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall   = (state_reg != IDLE);
    ctl_req = (state_reg == ENTER) || (state_reg == RETURN);
  end

  assign ctl_pc = ctl_pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie_reg      <= 1'b0;
      st_mpie_reg     <= 1'b0;
      irq_en_reg      <= '0;
      mip_reg         <= '0;
      mtvec_base_reg  <= RST_MTVEC[XLEN-1:2];
      mepc_reg        <= '0;
      mcause_intr_reg <= 1'b0;
      mcause_code_reg <= '0;
      mtval_reg       <= '0;
      ctl_pc_reg      <= '0;
    end else begin
      mip_reg <= {irq_ext, irq_tmr, irq_sft};
      if (csr_wen && csr_adr == ADR_MIE)
        irq_en_reg <= {csr_wdt[11], csr_wdt[7], csr_wdt[3]};
      if (csr_wen && csr_adr == ADR_MTVEC)
        mtvec_base_reg <= csr_wdt[XLEN-1:2];
      if (take_exc || take_irq) begin
        mepc_reg        <= exc_pc[XLEN-1:1];
        mcause_intr_reg <= take_irq;
        mcause_code_reg <= take_irq ? irq_code : exc_cause;
        mtval_reg       <= take_irq ? '0 : exc_tval;
        st_mpie_reg     <= st_mie_reg;
        st_mie_reg      <= 1'b0;
        ctl_pc_reg      <= trap_pc;
      end else if (take_ret) begin
        st_mie_reg  <= st_mpie_reg;
        st_mpie_reg <= 1'b1;
        ctl_pc_reg  <= {mepc_reg, 1'b0};
      end
      // Software writes to trap-state CSRs lose against a same-cycle entry/MRET.
      if (csr_wen && !hw_evt) begin
        case (csr_adr)
          ADR_MSTATUS: begin
            st_mie_reg  <= csr_wdt[3];
            st_mpie_reg <= csr_wdt[7];
          end
          ADR_MEPC:   mepc_reg <= csr_wdt[XLEN-1:1];
          ADR_MCAUSE: begin
            mcause_intr_reg <= csr_wdt[XLEN-1];
            mcause_code_reg <= csr_wdt[5:0];
          end
          ADR_MTVAL:  mtval_reg <= csr_wdt;
          default: ;
        endcase
      end
    end
  end

`ifdef RISCV_TRAP_VECTORED_EN
  logic [1:0] mtvec_mode_reg;
  // WARL: only DIRECT(0) and VECTORED(1) are legal; other values keep the old mode.
  always_ff @(posedge clk) begin
    if (rst)
      mtvec_mode_reg <= RST_MTVEC[1:0];
    else if (csr_wen && csr_adr == ADR_MTVEC && !csr_wdt[1])
      mtvec_mode_reg <= csr_wdt[1:0];
  end
  assign mtvec_mode = mtvec_mode_reg;
`else
  assign mtvec_mode = 2'b00;
`endif

  // mie/mip share the same bit positions 3, 7, 11.
  always_comb begin
    mie_rd = '0;
    mip_rd = '0;
    for (int i = 0; i < 3; i++) begin
      mie_rd[3+4*i] = irq_en_reg[i];
      mip_rd[3+4*i] = mip_reg[i];
    end
  end

  always_comb begin
    csr_rdt = '0;
    csr_ill = 1'b0;
    case (csr_adr)
      ADR_MSTATUS: begin
        csr_rdt[12:11] = 2'b11;
        csr_rdt[7]     = st_mpie_reg;
        csr_rdt[3]     = st_mie_reg;
      end
      ADR_MIE:    csr_rdt = mie_rd;
      ADR_MTVEC:  csr_rdt = {mtvec_base_reg, mtvec_mode};
      ADR_MEPC:   csr_rdt = {mepc_reg, 1'b0};
      ADR_MCAUSE: csr_rdt = {mcause_intr_reg, {(XLEN-7){1'b0}}, mcause_code_reg};
      ADR_MTVAL:  csr_rdt = mtval_reg;
      ADR_MIP:    csr_rdt = mip_rd;
      default:    csr_ill = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_riscv_trap_ctl.sv
// Scoreboarded random bench for riscv_trap_ctl against a per-cycle trap-rule model.
module tb_riscv_trap_ctl;
  logic        clk = 1'b0;
  logic        rst, exc_vld, ret_vld, irq_ext, irq_tmr, irq_sft, csr_wen;
  logic [5:0]  exc_cause;
  logic [63:0] exc_tval, exc_pc, csr_wdt, csr_rdt, ctl_pc;
  logic [11:0] csr_adr;
  logic        csr_ill, stall, ctl_req;

  riscv_trap_ctl dut (
    .clk(clk), .rst(rst), .exc_vld(exc_vld), .exc_cause(exc_cause), .exc_tval(exc_tval),
    .exc_pc(exc_pc), .ret_vld(ret_vld), .irq_ext(irq_ext), .irq_tmr(irq_tmr),
    .irq_sft(irq_sft), .csr_wen(csr_wen), .csr_adr(csr_adr), .csr_wdt(csr_wdt),
    .csr_rdt(csr_rdt), .csr_ill(csr_ill), .stall(stall), .ctl_req(ctl_req), .ctl_pc(ctl_pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  bit chk_en = 1'b0;

  typedef struct { int cyc; logic [63:0] pc; } redir_t;
  typedef struct { int cyc; logic [11:0] adr; logic [63:0] rdt; logic ill; } rd_t;
  redir_t rq[$];
  rd_t    dq[$];

  // Reference model state, as architecturally visible values.
  logic [63:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_en, m_mip;
  logic        m_mie, m_mpie, m_busy;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mtvec = 64'h0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_en = 0; m_mip = 0;
    m_mie = 0; m_mpie = 0; m_busy = 0;
  endtask

  function automatic void model_read(input logic [11:0] a, output logic [63:0] d, output logic ill);
    d = 0; ill = 0;
    case (a)
      12'h300: d = 64'h1800 | (64'(m_mpie) << 7) | (64'(m_mie) << 3);
      12'h304: d = m_en;
      12'h305: d = m_mtvec;
      12'h341: d = m_mepc;
      12'h342: d = m_mcause;
      12'h343: d = m_mtval;
      12'h344: d = m_mip;
      default: ill = 1;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [5:0] cause,
                            input logic [63:0] tval, input logic [63:0] pc, input logic ret,
                            input logic [2:0] irq, input logic wen, input logic [11:0] a,
                            input logic [63:0] wd);
    logic [63:0] pend, tgt;
    int code;
    bit evt;
    if (r) begin model_reset(); return; end
    evt = 0;
    pend = m_mip & m_en;
    if (m_busy) m_busy = 0;
    else if (e) begin
      tgt = m_mtvec & ~64'h3;
      m_mepc = pc & ~64'h1; m_mcause = 64'(cause); m_mtval = tval;
      m_mpie = m_mie; m_mie = 0; evt = 1;
    end else if (m_mie && pend != 0) begin
      code = pend[11] ? 11 : (pend[3] ? 3 : 7);
      tgt = (m_mtvec & ~64'h3) + ((m_mtvec[1:0] == 2'd1) ? 64'(4 * code) : 64'h0);
      m_mepc = pc & ~64'h1; m_mcause = (64'h1 << 63) | 64'(code); m_mtval = 0;
      m_mpie = m_mie; m_mie = 0; evt = 1;
    end else if (ret) begin
      tgt = m_mepc; m_mie = m_mpie; m_mpie = 1; evt = 1;
    end
    if (evt) begin
      redir_t x; x.cyc = cyc + 1; x.pc = tgt; rq.push_back(x); m_busy = 1;
    end
    if (wen) begin
      case (a)
        12'h300: if (!evt) begin m_mie = wd[3]; m_mpie = wd[7]; end
        12'h304: m_en = wd & 64'h888;
        12'h305: begin
`ifdef RISCV_TRAP_VECTORED_EN
          m_mtvec = (wd & ~64'h3) | ((wd[1:0] < 2'd2) ? 64'(wd[1:0]) : 64'(m_mtvec[1:0]));
`else
          m_mtvec = wd & ~64'h3;
`endif
        end
        12'h341: if (!evt) m_mepc = wd & ~64'h1;
        12'h342: if (!evt) m_mcause = wd & ((64'h1 << 63) | 64'h3F);
        12'h343: if (!evt) m_mtval = wd;
        default: ;
      endcase
    end
    m_mip = (64'(irq[2]) << 11) | (64'(irq[1]) << 7) | (64'(irq[0]) << 3);
  endtask

  // One cycle of stimulus: drive, queue expectations, advance the model, wait one edge.
  task automatic drive_cycle(input logic r, input logic e, input logic [5:0] cause,
                             input logic [63:0] tval, input logic [63:0] pc, input logic ret,
                             input logic [2:0] irq, input logic wen, input logic [11:0] a,
                             input logic [63:0] wd);
    rd_t x;
    rst = r; exc_vld = e; exc_cause = cause; exc_tval = tval; exc_pc = pc; ret_vld = ret;
    {irq_ext, irq_tmr, irq_sft} = irq; csr_wen = wen; csr_adr = a; csr_wdt = wd;
    x.cyc = cyc; x.adr = a;
    model_read(a, x.rdt, x.ill);
    dq.push_back(x);
    model_step(r, e, cause, tval, pc, ret, irq, wen, a, wd);
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [11:0] a);
    drive_cycle(0, 0, 0, 0, 0, 0, 3'b000, 0, a, 0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    drive_cycle(0, 0, 0, 0, 0, 0, 3'b000, 1, a, d);
  endtask

  // Monitor: redirects and CSR reads checked against the scoreboard queues.
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_req;
      exp_req = (rq.size() > 0 && rq[0].cyc == cyc);
      chk("ctl_req", 64'(ctl_req), 64'(exp_req));
      chk("stall", 64'(stall), 64'(exp_req));
      if (exp_req) begin
        chk("ctl_pc", ctl_pc, rq[0].pc);
        $display("redirect cyc=%0d pc=%h", cyc, ctl_pc);
        void'(rq.pop_front());
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) void'(rq.pop_front());
      if (dq.size() > 0 && dq[0].cyc == cyc) begin
        chk($sformatf("rdt@%h", dq[0].adr), csr_rdt, dq[0].rdt);
        chk($sformatf("ill@%h", dq[0].adr), 64'(csr_ill), 64'(dq[0].ill));
        void'(dq.pop_front());
      end
    end
  end

  logic [11:0] adrs [9] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                            12'h343, 12'h344, 12'h7C0, 12'h301};

  initial begin
    logic [2:0] irq_v;
    rst = 1; exc_vld = 0; exc_cause = 0; exc_tval = 0; exc_pc = 0; ret_vld = 0;
    irq_ext = 0; irq_tmr = 0; irq_sft = 0; csr_wen = 0; csr_adr = 0; csr_wdt = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_ctl_pc", ctl_pc, 64'h0);
    chk_en = 1'b1;
    foreach (adrs[i]) rd(adrs[i]);

    // Synchronous exception into direct base.
    wr(12'h305, 64'h8000);
    drive_cycle(0, 1, 6'd2, 64'hDEAD, 64'h1000, 0, 3'b000, 0, 12'h341, 0);
    rd(12'h341); rd(12'h342); rd(12'h343); rd(12'h300);
    // Interrupt masked by MIE, then enabled by CSR write; MEI wins over MTI.
    wr(12'h304, 64'h888);
    drive_cycle(0, 0, 0, 0, 64'h3000, 0, 3'b110, 0, 12'h344, 0);
    drive_cycle(0, 0, 0, 0, 64'h3000, 0, 3'b110, 1, 12'h300, 64'h8);
    drive_cycle(0, 0, 0, 0, 64'h3004, 0, 3'b110, 0, 12'h342, 0);
    drive_cycle(0, 0, 0, 0, 64'h3004, 0, 3'b000, 0, 12'h342, 0);
    drive_cycle(0, 0, 0, 0, 0, 1, 3'b000, 0, 12'h300, 0);
    rd(12'h300);
    // Vectored timer interrupt, then illegal MODE write.
    wr(12'h305, 64'h8001);
    drive_cycle(0, 0, 0, 0, 64'h4000, 0, 3'b010, 0, 12'h305, 0);
    drive_cycle(0, 0, 0, 0, 64'h4000, 0, 3'b010, 0, 12'h305, 0);
    drive_cycle(0, 0, 0, 0, 64'h4000, 0, 3'b000, 1, 12'h305, 64'h8002);
    rd(12'h305);
    // Exception, MRET and pending interrupt together; then reset during ENTER.
    wr(12'h300, 64'h8);
    drive_cycle(0, 0, 0, 0, 0, 0, 3'b001, 0, 12'h300, 0);
    drive_cycle(0, 1, 6'd5, 64'h77, 64'h5000, 1, 3'b001, 0, 12'h300, 0);
    drive_cycle(1, 0, 0, 0, 0, 0, 3'b001, 0, 12'h341, 0);
    foreach (adrs[i]) rd(adrs[i]);
    wr(12'h341, 64'h2001); rd(12'h341); wr(12'h7C0, 64'h1234); rd(12'h7C0);

    irq_v = 3'b000;
    for (int n = 0; n < 1500; n++) begin
      logic [63:0] wd;
      logic [11:0] a;
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 7) == 0) irq_v[b] = ~irq_v[b];
      a = adrs[$urandom_range(0, 8)];
      wd = {$urandom, $urandom};
      drive_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
                  6'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 7) == 0, irq_v, $urandom_range(0, 3) == 0, a, wd);
    end
    rd(12'h300); rd(12'h300);
    chk("redirect_queue_empty", 64'(rq.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
